// File: rtl/irq_timer_ctrl.sv
// irq_timer_ctrl: memory-mapped interrupt controller with an integrated reload timer.
// Source 0 is the internal timer overflow; sources 1..NSRC-1 are external,
// rising-edge sensitive requests. Drives the CPU interrupt request and records
// the cause of each taken interrupt.
module irq_timer_ctrl #(
  parameter int unsigned NSRC = 4,
  parameter logic [31:0] BASE = 32'h4000_0000
) (
  input  logic            clk,
  input  logic            reset,       // asynchronous, active low
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  input  logic            MemWr,
  input  logic            MemRd,
  output logic [31:0]     rdata,       // combinational, 0 when not selected
  output logic            hit,         // combinational address decode
  input  logic [NSRC-2:0] irq_in,
  input  logic            super_mode,  // CPU kernel-mode flag (PC[31])
  output logic            IRQsig
);

  localparam int unsigned CW       = $clog2(NSRC + 1);
  localparam logic [31:0] WIN_SIZE = 32'h18;
  localparam logic [31:0] TL_MAX   = 32'hFFFF_FFFF;

  localparam logic [2:0] REG_TH    = 3'd0;
  localparam logic [2:0] REG_TL    = 3'd1;
  localparam logic [2:0] REG_TCON  = 3'd2;
  localparam logic [2:0] REG_IEN   = 3'd3;
  localparam logic [2:0] REG_IPEND = 3'd4;
  localparam logic [2:0] REG_CAUSE = 3'd5;

  logic [31:0]     offset;
  logic [2:0]      reg_sel;
  logic            wr_en;
  logic            wr_th, wr_tl, wr_tcon, wr_ien, wr_ipend;

  logic [31:0]     th;
  logic [31:0]     tl;
  logic            run;
  logic [NSRC-1:0] ien;
  logic [NSRC-1:0] pend;
  logic [CW-1:0]   cause;

  logic [NSRC-2:0] irq_smp;
  logic [NSRC-2:0] irq_prev;
  logic [NSRC-2:0] irq_rise;

  logic            ovf;
  logic [NSRC-1:0] pend_set;
  logic [NSRC-1:0] pend_clr;
  logic [NSRC-1:0] active;
  logic [CW-1:0]   take_cause;
  logic            take;

  // Window decode: word-aligned offsets 0x00..0x14 above BASE
  always_comb begin
    offset  = addr - BASE;
    hit     = (offset < WIN_SIZE) && (offset[1:0] == 2'b00);
    reg_sel = offset[4:2];
  end

  // Register write strobes
  always_comb begin
    wr_en    = MemWr && hit;
    wr_th    = wr_en && (reg_sel == REG_TH);
    wr_tl    = wr_en && (reg_sel == REG_TL);
    wr_tcon  = wr_en && (reg_sel == REG_TCON);
    wr_ien   = wr_en && (reg_sel == REG_IEN);
    wr_ipend = wr_en && (reg_sel == REG_IPEND);
  end

  // Combinational read mux
  always_comb begin
    rdata = '0;
    if (MemRd && hit) begin
      case (reg_sel)
        REG_TH:    rdata = th;
        REG_TL:    rdata = tl;
        REG_TCON:  rdata = {31'd0, run};
        REG_IEN:   rdata = 32'(ien);
        REG_IPEND: rdata = 32'(pend);
        REG_CAUSE: rdata = 32'(cause);
        default:   rdata = '0;
      endcase
    end
  end

  // Timer overflow only when the counter really wraps (a TL write overrides it)
  always_comb begin
    ovf = run && (tl == TL_MAX) && !wr_tl;
  end

  // Edge detect on the registered external samples
  always_comb begin
    irq_rise = irq_smp & ~irq_prev;
  end

  // Pending set/clear vectors; set beats a simultaneous write-1-to-clear
  always_comb begin
    pend_set = {irq_rise, ovf};
    pend_clr = wr_ipend ? wdata[NSRC-1:0] : '0;
    active   = pend & ien;
  end

  // Lowest-numbered active source wins; 0 means nothing active
  always_comb begin
    take_cause = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (active[i]) take_cause = CW'(i + 1);
    end
  end

  // Take event: CPU vectors when the request is seen in user mode
  always_comb begin
    take = IRQsig && !super_mode;
  end

  // Timer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th  <= '0;
      tl  <= '0;
      run <= 1'b0;
    end else begin
      if (wr_th)   th  <= wdata;
      if (wr_tcon) run <= wdata[0];
      if (wr_tl) begin
        tl <= wdata;
      end else if (run) begin
        tl <= (tl == TL_MAX) ? th : tl + 32'd1;
      end
    end
  end

  // Enable, pending and cause registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ien   <= '0;
      pend  <= '0;
      cause <= '0;
    end else begin
      if (wr_ien) ien <= wdata[NSRC-1:0];
      pend <= (pend & ~pend_clr) | pend_set;
      if (take) cause <= take_cause;
    end
  end

  // External request sampling and edge-detect history
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_smp  <= '0;
      irq_prev <= '0;
    end else begin
      irq_smp  <= irq_in;
      irq_prev <= irq_smp;
    end
  end

  // Registered interrupt request, masked in kernel mode
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      IRQsig <= 1'b0;
    end else begin
      IRQsig <= (|active) && !super_mode;
    end
  end

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// tb_irq_timer_ctrl: directed bench for irq_timer_ctrl with an expected-value queue.
module tb_irq_timer_ctrl;

  localparam int unsigned NSRC = 4;
  localparam logic [31:0] BASE = 32'h4000_0000;

  localparam logic [31:0] A_TH    = BASE + 32'h00;
  localparam logic [31:0] A_TL    = BASE + 32'h04;
  localparam logic [31:0] A_TCON  = BASE + 32'h08;
  localparam logic [31:0] A_IEN   = BASE + 32'h0C;
  localparam logic [31:0] A_IPEND = BASE + 32'h10;
  localparam logic [31:0] A_CAUSE = BASE + 32'h14;

  logic            clk;
  logic            reset;
  logic [31:0]     addr;
  logic [31:0]     wdata;
  logic            MemWr;
  logic            MemRd;
  logic [31:0]     rdata;
  logic            hit;
  logic [NSRC-2:0] irq_in;
  logic            super_mode;
  logic            IRQsig;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  irq_timer_ctrl #(.NSRC(NSRC), .BASE(BASE)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
    .MemWr(MemWr), .MemRd(MemRd), .rdata(rdata), .hit(hit),
    .irq_in(irq_in), .super_mode(super_mode), .IRQsig(IRQsig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h, required a queued expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  // Called at a negedge; the write lands on the following posedge, returns at next negedge
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    MemWr = 1'b1;
    @(negedge clk);
    MemWr = 1'b0;
    addr  = '0;
    wdata = '0;
  endtask

  task automatic exp_rd(input string tag, input logic [31:0] a, input logic [31:0] val);
    logic [31:0] d;
    push(tag, val);
    addr  = a;
    MemRd = 1'b1;
    #1;
    d     = rdata;
    MemRd = 1'b0;
    addr  = '0;
    check(d);
  endtask

  task automatic exp_irq(input string tag, input logic val);
    push(tag, 32'(val));
    check(32'(IRQsig));
  endtask

  task automatic exp_hit(input string tag, input logic [31:0] a, input logic val);
    logic h;
    push(tag, 32'(val));
    addr = a;
    #1;
    h    = hit;
    addr = '0;
    check(32'(h));
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    reset      = 1'b0;
    addr       = '0;
    wdata      = '0;
    MemWr      = 1'b0;
    MemRd      = 1'b0;
    irq_in     = '0;
    super_mode = 1'b0;

    // 1. Reset state
    cyc(2);
    exp_rd("rst_th", A_TH, 32'h0);
    exp_rd("rst_tl", A_TL, 32'h0);
    exp_irq("rst_irq", 1'b0);
    reset = 1'b1;
    cyc(1);
    exp_rd("th0", A_TH, 32'h0);
    exp_rd("tl0", A_TL, 32'h0);
    exp_rd("tcon0", A_TCON, 32'h0);
    exp_rd("ien0", A_IEN, 32'h0);
    exp_rd("ipend0", A_IPEND, 32'h0);
    exp_rd("cause0", A_CAUSE, 32'h0);
    exp_irq("irq0", 1'b0);
    exp_hit("hit_cause", A_CAUSE, 1'b1);
    exp_hit("hit_past", BASE + 32'h18, 1'b0);
    exp_hit("hit_unal", BASE + 32'h02, 1'b0);
    exp_hit("hit_below", BASE - 32'h04, 1'b0);
    wr(BASE + 32'h18, 32'h1234_5678);
    wr(BASE + 32'h01, 32'hFFFF_FFFF);
    exp_rd("ignored_wr", A_TH, 32'h0);
    wr(A_TCON, 32'hFFFF_FFFE);
    exp_rd("tcon_bit0", A_TCON, 32'h0);

    // 2. Timer overflow and reload
    wr(A_TH, 32'hFFFF_FFFD);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_IEN, 32'h1);
    wr(A_TCON, 32'h1);
    exp_rd("tl_start", A_TL, 32'hFFFF_FFFE);
    exp_rd("tcon_run", A_TCON, 32'h1);
    cyc(1);
    exp_rd("tl_max", A_TL, 32'hFFFF_FFFF);
    exp_rd("pend_pre_ovf", A_IPEND, 32'h0);
    cyc(1);
    exp_rd("tl_reload", A_TL, 32'hFFFF_FFFD);
    exp_rd("pend_ovf", A_IPEND, 32'h1);
    exp_irq("irq_pre_ovf", 1'b0);
    cyc(1);
    exp_irq("irq_ovf", 1'b1);
    exp_rd("tl_count", A_TL, 32'hFFFF_FFFE);
    cyc(1);
    exp_rd("cause_tmr", A_CAUSE, 32'h1);

    // 5. Set beats W1C on the same edge
    wr(A_TCON, 32'h0);
    wr(A_IPEND, 32'hF);
    exp_rd("pend_clr", A_IPEND, 32'h0);
    wr(A_TH, 32'hFFFF_FFFF);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TCON, 32'h1);
    wr(A_IPEND, 32'h1);
    exp_rd("set_wins", A_IPEND, 32'h1);
    exp_rd("tl_th_max", A_TL, 32'hFFFF_FFFF);
    wr(A_TCON, 32'h0);
    wr(A_IPEND, 32'hF);
    exp_rd("pend_clr2", A_IPEND, 32'h0);

    // 3. Two external edges, priority to the lower source
    wr(A_IEN, 32'hE);
    cyc(2);
    exp_irq("irq_idle", 1'b0);
    irq_in = 3'b101;
    cyc(1);
    irq_in = 3'b000;
    cyc(1);
    exp_rd("ipend_ext", A_IPEND, 32'hA);
    exp_irq("irq_lat1", 1'b0);
    cyc(1);
    exp_irq("irq_lat2", 1'b1);
    cyc(1);
    exp_rd("cause_ext", A_CAUSE, 32'h2);

    // 4. Kernel mode masks the request
    super_mode = 1'b1;
    cyc(1);
    exp_irq("irq_super", 1'b0);
    wr(A_IPEND, 32'hF);
    super_mode = 1'b0;
    cyc(1);
    exp_irq("irq_after_clr", 1'b0);
    exp_rd("ipend_after_clr", A_IPEND, 32'h0);
    exp_rd("cause_held", A_CAUSE, 32'h2);

    // 6. Pending while disabled, then enabled; then a spurious take
    wr(A_IEN, 32'h0);
    irq_in = 3'b001;
    cyc(1);
    irq_in = 3'b000;
    cyc(3);
    exp_rd("ipend_masked", A_IPEND, 32'h2);
    exp_irq("irq_masked", 1'b0);
    wr(A_IEN, 32'h2);
    exp_irq("irq_en_same", 1'b0);
    cyc(1);
    exp_irq("irq_en", 1'b1);
    wr(A_IPEND, 32'h2);
    exp_rd("cause_src1", A_CAUSE, 32'h2);
    exp_irq("irq_stale", 1'b1);
    cyc(1);
    exp_rd("cause_spur", A_CAUSE, 32'h0);
    exp_irq("irq_dropped", 1'b0);

    // Reset mid-operation
    wr(A_TH, 32'h0);
    wr(A_TL, 32'h0);
    wr(A_IEN, 32'h1);
    wr(A_TCON, 32'h1);
    cyc(2);
    exp_rd("tl_running", A_TL, 32'h2);
    #2;
    reset = 1'b0;
    #1;
    exp_rd("mid_rst_tl", A_TL, 32'h0);
    exp_rd("mid_rst_ien", A_IEN, 32'h0);
    exp_irq("mid_rst_irq", 1'b0);
    cyc(1);
    reset = 1'b1;
    cyc(2);
    exp_rd("post_rst_tl", A_TL, 32'h0);
    exp_rd("post_rst_tcon", A_TCON, 32'h0);

    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_left: observed %0d entries, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_timer_ctrl.md
# irq_timer_ctrl

Memory-mapped interrupt controller with an integrated reload timer for the single-cycle CPU. It latches interrupt requests from the timer and external sources and applies per-source enables. It drives the `IRQsig` input of the control unit and records which source was taken when the CPU enters kernel mode. The block sits on the data-memory bus beside data RAM, decoded by address.

## Interface
Parameters:
- `NSRC`, 4, number of interrupt sources. Source 0 is the internal timer; sources 1..NSRC-1 are external.
- `BASE`, 32'h40000000, base byte address of the register window.

Ports:
- `clk`, input, 1, system clock.
- `reset`, input, 1, asynchronous, active-low reset.
- `addr`, input, 32, data-bus byte address.
- `wdata`, input, 32, write data.
- `MemWr`, input, 1, bus write strobe.
- `MemRd`, input, 1, bus read strobe.
- `rdata`, output, 32, read data. Combinational; 0 when not selected.
- `hit`, output, 1, address falls in `BASE`..`BASE+0x17`, word-aligned.
- `irq_in`, input, NSRC-1, external requests, synchronous to `clk`, rising-edge sensitive. Bit i maps to source i+1.
- `super`, input, 1, CPU kernel-mode flag (PC[31]).
- `IRQsig`, output, 1, interrupt request to the control unit. Registered.

## Operation
Register map (offset, access, reset value 0 for all):
- 0x00 TH: RW, timer reload value.
- 0x04 TL: RW, timer count.
- 0x08 TCON: RW. Bit0 = run; bits 31:1 read as 0.
- 0x0C IEN: RW, bits NSRC-1:0 are per-source enables.
- 0x10 IPEND: reads pending bits; a write clears each bit where `wdata` = 1 (write-1-to-clear).
- 0x14 CAUSE: RO. Holds the source index + 1 of the last taken interrupt; 0 = none.

Bus rules:
- A write takes effect at the clock edge when `MemWr` && `hit`.
- Reads are combinational when `MemRd` && `hit`.
- Unmapped or unaligned offsets inside the window read 0; writes to them are ignored.

Timer:
- While TCON.run = 1, TL increments each cycle.
- When TL == 32'hFFFFFFFF, next TL = TH and pend[0] sets (overflow).
- A bus write to TL overrides the increment in the same cycle.
- TH writes do not affect TL until the next reload.

Pending logic:
- pend[i] (i ≥ 1) sets on a rising edge of `irq_in[i-1]`, detected by comparing against the previous-cycle sample.
- If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- Pending bits set regardless of IEN; IEN only gates the request.

Request and take:
- `IRQsig` ← |(pend & IEN) & ~`super`, registered.
- Take event: an edge where `IRQsig` = 1 and `super` = 0. At that edge the CPU vectors to the handler.
- On the take event, CAUSE latches 1 + the index of the lowest-numbered bit of (pend & IEN), sampled that cycle. Source 0 has the highest priority.
- The block does not clear pend; the handler must clear it via IPEND.
- If pend is cleared but IRQsig is still high on an edge with `super` = 0, CAUSE latches 0 (spurious take).

## Timing
- Reset (asynchronous, while `reset` = 0): all registers, `IRQsig`, and the edge-detect history go to 0. `rdata` and `hit` are combinational.
- Request latency: external rising edge at edge N sets pend at edge N+1; `IRQsig` rises at edge N+2 (if enabled and `super` = 0).
- Overflow latency: TL == FFFFFFFF at edge N gives pend[0] = 1 and TL = TH after edge N; `IRQsig` = 1 after edge N+1.
- Mask and unmask: `IRQsig` falls one cycle after `super` rises or after IEN/IPEND removes the last active bit.
- Reset asserted mid-operation aborts counting and clears pending state immediately; there is no partial state after release.
- TH = FFFFFFFF with run = 1 gives an overflow every cycle.

## Test plan
1. Reset with `reset` = 0 → all reads return 0 and `IRQsig` = 0. Release reset and read TH/TL/TCON/IEN/IPEND/CAUSE → all 0.
2. TH = FFFFFFFD, TL = FFFFFFFE, IEN = 1, TCON = 1 → TL = FFFFFFFF after 1 cycle; pend[0] set and TL = FFFFFFFD after 2; `IRQsig` = 1 after 3.
3. IEN = 4'b1110; pulse `irq_in` bits 0 and 2 in the same cycle with `super` = 0 → IPEND = 4'b1010, `IRQsig` rises 2 cycles later, and on the take edge CAUSE = 2.
4. Assert `super` = 1 while pend & IEN ≠ 0 → `IRQsig` = 0 next cycle. Write IPEND = F, then drop `super` → `IRQsig` stays 0 and IPEND = 0.
5. Write IPEND = 1 in the same cycle as a timer overflow → pend[0] remains 1.
6. Source 1 pending but IEN = 0 → `IRQsig` stays 0. Write IEN = 2 → `IRQsig` = 1 one cycle later.
